// File: rtl/matrix_job_ctrl.sv
// Job sequencer for the matrix datapath: counts A/B loads, launches one calc op,
// then streams memory C into the UART transmitter under a busy handshake.
module matrix_job_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int WORDS        = 1024,
    parameter int RD_LAT       = 1,
    parameter int CALC_TIMEOUT = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_write_start,
    input  logic              i_wea,
    input  logic              i_web,
    input  logic [2:0]        i_op,
    input  logic              i_op_go,
    input  logic              i_finish,
    input  logic              i_tx_busy,
    output logic              o_op_start,
    output logic [2:0]        o_op_sel,
    output logic [ADDR_W-1:0] o_addrc_r,
    output logic              o_tx_valid,
    output logic              o_loaded,
    output logic              o_job_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int WD_W  = $clog2(CALC_TIMEOUT + 1);
    localparam int LAT_W = $clog2(RD_LAT + 2);

    typedef enum logic [2:0] {
        IDLE, LOAD, READY, CALC, S_ADDR, S_REQ, S_ACK, S_DRAIN
    } state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt_a, r_cnt_b, w_cnt_a, w_cnt_b, w_cnt_a_inc, w_cnt_b_inc;
    logic [WD_W-1:0]    r_wdog, w_wdog;
    logic [LAT_W-1:0]   r_lat, w_lat;
    logic [ADDR_W-1:0]  r_addrc, w_addrc;
    logic [2:0]         r_op_sel, w_op_sel;
    logic               r_op_start, r_tx_valid, r_loaded, r_job_busy, r_done, r_err;
    logic               w_op_start, w_tx_valid, w_loaded, w_job_busy, w_done, w_err;

    // Saturating load counters; the last strobe of each stream is counted on the
    // same edge that moves to READY, so both A and B may finish together.
    assign w_cnt_a_inc = (i_wea && r_cnt_a != CNT_W'(WORDS)) ? r_cnt_a + CNT_W'(1) : r_cnt_a;
    assign w_cnt_b_inc = (i_web && r_cnt_b != CNT_W'(WORDS)) ? r_cnt_b + CNT_W'(1) : r_cnt_b;

    always_comb begin
        w_state    = r_state;
        w_cnt_a    = r_cnt_a;
        w_cnt_b    = r_cnt_b;
        w_wdog     = r_wdog;
        w_lat      = r_lat;
        w_addrc    = r_addrc;
        w_op_sel   = r_op_sel;
        w_loaded   = r_loaded;
        w_op_start = 1'b0;
        w_tx_valid = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            IDLE: if (i_write_start) begin
                w_state = LOAD;
                w_cnt_a = '0;
                w_cnt_b = '0;
            end
            LOAD: begin
                w_cnt_a = w_cnt_a_inc;
                w_cnt_b = w_cnt_b_inc;
                if (w_cnt_a_inc == CNT_W'(WORDS) && w_cnt_b_inc == CNT_W'(WORDS)) begin
                    w_state  = READY;
                    w_loaded = 1'b1;
                end
            end
            READY: begin
                if (i_write_start) begin
                    w_state  = LOAD;
                    w_loaded = 1'b0;
                    w_cnt_a  = '0;
                    w_cnt_b  = '0;
                end else if (i_op_go) begin
                    if (i_op <= 3'd4) begin
                        w_state    = CALC;
                        w_op_sel   = i_op;
                        w_op_start = 1'b1;
                        w_wdog     = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            CALC: begin
                if (i_finish) begin
                    w_state = S_ADDR;
                    w_addrc = '0;
                    w_lat   = '0;
                end else if (r_wdog == WD_W'(CALC_TIMEOUT - 1)) begin
                    w_state = READY;
                    w_err   = 1'b1;
                end else begin
                    w_wdog = r_wdog + WD_W'(1);
                end
            end
            S_ADDR: begin
                if (r_lat == LAT_W'(RD_LAT)) w_state = S_REQ;
                else                         w_lat   = r_lat + LAT_W'(1);
            end
            S_REQ: if (!i_tx_busy) begin
                w_state    = S_ACK;
                w_tx_valid = 1'b1;
            end
            S_ACK: if (i_tx_busy) w_state = S_DRAIN;
            S_DRAIN: if (!i_tx_busy) begin
                if (r_addrc == ADDR_W'(WORDS - 1)) begin
                    w_state = READY;
                    w_done  = 1'b1;
                end else begin
                    w_state = S_ADDR;
                    w_addrc = r_addrc + ADDR_W'(1);
                    w_lat   = '0;
                end
            end
            default: w_state = IDLE;
        endcase
        w_job_busy = (w_state != IDLE) && (w_state != LOAD) && (w_state != READY);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_wdog     <= '0;
            r_lat      <= '0;
            r_addrc    <= '0;
            r_op_sel   <= '0;
            r_op_start <= 1'b0;
            r_tx_valid <= 1'b0;
            r_loaded   <= 1'b0;
            r_job_busy <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt_a    <= w_cnt_a;
            r_cnt_b    <= w_cnt_b;
            r_wdog     <= w_wdog;
            r_lat      <= w_lat;
            r_addrc    <= w_addrc;
            r_op_sel   <= w_op_sel;
            r_op_start <= w_op_start;
            r_tx_valid <= w_tx_valid;
            r_loaded   <= w_loaded;
            r_job_busy <= w_job_busy;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    assign o_op_start = r_op_start;
    assign o_op_sel   = r_op_sel;
    assign o_addrc_r  = r_addrc;
    assign o_tx_valid = r_tx_valid;
    assign o_loaded   = r_loaded;
    assign o_job_busy = r_job_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
endmodule
